// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, constants and dump FSM state type
package regfile_pkg;

    localparam int RegNum       = 32;
    localparam int RegWidth     = 32;
    localparam int RegAddrWidth = 5;

    localparam logic [RegWidth-1:0] ZeroWord    = '0;
    localparam logic                RstEnable   = 1'b1;
    localparam logic                WriteEnable = 1'b1;
    localparam logic                ReadEnable  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } dump_state_t;

endpackage

// File: rtl/regfile_dump.sv
// rtl/regfile_dump.sv - dump sequencer streaming registers 0..31 over a valid/ready handshake
module regfile_dump
    import regfile_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    dump_req_i,
    input  logic                    dump_ready_i,
    input  logic [RegWidth-1:0]     rd_data_i,
    output logic [RegAddrWidth-1:0] rd_addr_o,
    output logic                    dump_valid_o,
    output logic [RegAddrWidth-1:0] dump_addr_o,
    output logic [RegWidth-1:0]     dump_data_o,
    output logic                    dump_last_o,
    output logic                    dump_busy_o
);

    localparam logic [RegAddrWidth-1:0] LastIdx = RegAddrWidth'(RegNum - 1);

    dump_state_t             state_q, state_d;
    logic [RegAddrWidth-1:0] idx_q, idx_d;
    logic                    active;

    always_ff @(posedge clk_i) begin
        if (rst_i == RstEnable) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs are forced quiet while reset is high so an aborted dump emits no stray beat.
    assign active = (state_q == DUMP) && (rst_i != RstEnable);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dump_valid_o = 1'b0;
        dump_busy_o  = 1'b0;
        dump_addr_o  = '0;
        dump_data_o  = ZeroWord;
        dump_last_o  = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (dump_req_i) begin
                    state_d = DUMP;
                end
            end
            DUMP: begin
                if (active) begin
                    dump_valid_o = 1'b1;
                    dump_busy_o  = 1'b1;
                    dump_addr_o  = idx_q;
                    dump_data_o  = rd_data_i;
                    dump_last_o  = (idx_q == LastIdx);
                end
                if (dump_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign rd_addr_o = idx_q;

endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 MIPS register file, two read ports, one write port, dump stream; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile
    import regfile_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [RegAddrWidth-1:0] waddr,
    input  logic [RegWidth-1:0]     wdata,
    input  logic                    re1,
    input  logic [RegAddrWidth-1:0] raddr1,
    output logic [RegWidth-1:0]     rdata1,
    input  logic                    re2,
    input  logic [RegAddrWidth-1:0] raddr2,
    output logic [RegWidth-1:0]     rdata2,
    input  logic                    dump_req_i,
    output logic                    dump_valid_o,
    input  logic                    dump_ready_i,
    output logic [RegAddrWidth-1:0] dump_addr_o,
    output logic [RegWidth-1:0]     dump_data_o,
    output logic                    dump_last_o,
    output logic                    dump_busy_o
);

    // $0 is hardwired to zero, so storage covers $1..$31 only.
    logic [RegWidth-1:0]     regs_q [1:RegNum-1];
    logic [RegAddrWidth-1:0] dump_rd_addr;
    logic [RegWidth-1:0]     dump_rd_data;
    logic [RegWidth-1:0]     stored1, stored2;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 1; i < RegNum; i++) begin
                regs_q[i] <= ZeroWord;
            end
        end else if ((we == WriteEnable) && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        stored1      = (raddr1 == '0) ? ZeroWord : regs_q[raddr1];
        stored2      = (raddr2 == '0) ? ZeroWord : regs_q[raddr2];
        dump_rd_data = (dump_rd_addr == '0) ? ZeroWord : regs_q[dump_rd_addr];
    end

    always_comb begin
        rdata1 = ZeroWord;
        if ((rst != RstEnable) && (re1 == ReadEnable) && (raddr1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            rdata1 = ((we == WriteEnable) && (raddr1 == waddr)) ? wdata : stored1;
`else
            rdata1 = stored1;
`endif
        end
    end

    always_comb begin
        rdata2 = ZeroWord;
        if ((rst != RstEnable) && (re2 == ReadEnable) && (raddr2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            rdata2 = ((we == WriteEnable) && (raddr2 == waddr)) ? wdata : stored2;
`else
            rdata2 = stored2;
`endif
        end
    end

    regfile_dump u_dump (
        .clk_i        (clk),
        .rst_i        (rst),
        .dump_req_i   (dump_req_i),
        .dump_ready_i (dump_ready_i),
        .rd_data_i    (dump_rd_data),
        .rd_addr_o    (dump_rd_addr),
        .dump_valid_o (dump_valid_o),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .dump_busy_o  (dump_busy_o)
    );

endmodule
